// File: rtl/rlwe_instr_sequencer.sv
// Instruction queue and IDLE/RUN/DONE dispatcher driving the RLWE NTT/arith/CRT processor.
// Optional watchdog enabled by defining RLWE_SEQ_TIMEOUT_EN.
module rlwe_instr_sequencer #(
  parameter int unsigned CORE_INDEX  = 1,
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  input  logic [7:0]                instruction,
  input  logic                      mod_sel_in,
  output logic                      instr_ready,
  output logic [$clog2(QDEPTH):0]   queue_count,
  input  logic                      done_nt,
  output logic                      enable_ld,
  output logic                      enable_nc,
  output logic                      enable_ac,
  output logic                      enable_crt,
  output logic [1:0]                instruction_ld,
  output logic [1:0]                instruction_nc,
  output logic [1:0]                ntt_iteration,
  output logic                      add_conv,
  output logic                      modulus_sel,
  output logic                      busy,
  output logic                      computation_done,
  output logic [1:0]                err_code,
  input  logic                      err_clr
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] OP_REARR = 8'd16;
  localparam logic [7:0] OP_NTT   = 8'd17;
  localparam logic [7:0] OP_INTT  = 8'd18;
  localparam logic [7:0] OP_MUL   = 8'd19;
  localparam logic [7:0] OP_ADD   = 8'd20;
  localparam logic [7:0] OP_CRT   = 8'd21;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  logic [8:0]    r_mem [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_op;
  logic          r_mod;
  logic [1:0]    r_err;
  logic          w_push;
  logic          w_pop;
  logic          w_legal;
  logic          w_start;
  logic          w_tmo;
  logic [8:0]    w_head;
  logic [1:0]    w_err_set;

  assign instr_ready = (r_count < CW'(QDEPTH));
  assign queue_count = r_count;
  assign w_push      = instr_valid && instr_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_start     = w_pop && w_legal;
  assign w_err_set   = {w_tmo, w_pop && !w_legal};

  // Opcode legality of the queue head; rearrange exists only on core 0
  always_comb begin
    w_legal = 1'b0;
    case (w_head[7:0])
      OP_REARR:                                 w_legal = (CORE_INDEX == 0);
      OP_NTT, OP_INTT, OP_MUL, OP_ADD, OP_CRT:  w_legal = 1'b1;
      default:                                  w_legal = 1'b0;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {mod_sel_in, instruction};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RLWE_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Counts RUN cycles since dispatch; fires on the last allowed cycle without done_nt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign w_tmo = (r_state == S_RUN) && !done_nt && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^32'(TIMEOUT_CYC);
  assign w_tmo        = 1'b0;
`endif

  // Latched instruction, modulus set and sticky errors (a new error beats err_clr)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_mod <= 1'b0;
      r_err <= '0;
    end else begin
      if (w_start) begin
        r_op  <= w_head[7:0];
        r_mod <= w_head[8];
      end
      r_err <= (r_err & ~{2{err_clr}}) | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (done_nt || w_tmo) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Unit enables decode from the latched opcode, only while RUN
  always_comb begin
    enable_nc        = 1'b0;
    enable_ac        = 1'b0;
    enable_crt       = 1'b0;
    instruction_nc   = 2'd0;
    add_conv         = 1'b0;
    busy             = (r_state != S_IDLE);
    computation_done = (r_state == S_DONE);
    if (r_state == S_RUN) begin
      case (r_op)
        OP_REARR: begin enable_nc = 1'b1; instruction_nc = 2'd2; end
        OP_NTT:   begin enable_nc = 1'b1; instruction_nc = 2'd0; end
        OP_INTT:  begin enable_nc = 1'b1; instruction_nc = 2'd1; end
        OP_MUL:   begin enable_ac = 1'b1; add_conv = 1'b1; end
        OP_ADD:   begin enable_ac = 1'b1; add_conv = 1'b0; end
        OP_CRT:   enable_crt = 1'b1;
        default:  ;
      endcase
    end
  end

  assign enable_ld      = 1'b0;
  assign instruction_ld = 2'd0;
  assign ntt_iteration  = 2'd0;
  assign modulus_sel    = r_mod;
  assign err_code       = r_err;

endmodule
